// File: rtl/rc5_pkg.sv
// Shared RC5-16 constants and the key-expansion state type.
package rc5_pkg;

    localparam int WORD_W      = 16;
    localparam int NUM_SUBKEYS = 34;

    localparam logic [WORD_W-1:0] P16 = 16'hB7E1;
    localparam logic [WORD_W-1:0] Q16 = 16'h9E37;

    typedef enum logic [1:0] {
        KE_IDLE,
        KE_INIT,
        KE_MIX,
        KE_DONE
    } ke_state_t;

    // Number of mixing steps: three passes over the larger of S and L.
    function automatic int mix_steps(input int key_words);
        return 3 * ((key_words > NUM_SUBKEYS) ? key_words : NUM_SUBKEYS);
    endfunction

endpackage

// File: rtl/rc5_key_expand_if.sv
// Host/round-core facing signals of the RC5 key-schedule engine.
interface rc5_key_expand_if #(
    parameter int KEY_BYTES = 16
);
    import rc5_pkg::*;

    logic                      start;
    logic [8*KEY_BYTES-1:0]    key_in;
    logic                      busy;
    logic                      keys_valid;
    logic [WORD_W-1:0]         subkeys [0:NUM_SUBKEYS-1];

    modport master (
        output start,
        output key_in,
        input  busy,
        input  keys_valid,
        input  subkeys
    );

    modport slave (
        input  start,
        input  key_in,
        output busy,
        output keys_valid,
        output subkeys
    );

endinterface

// File: rtl/rc5_key_expand_rotl.sv
// 16-bit rotate-left by a 4-bit amount.
module rotl (
    input  logic [15:0] data_i,
    input  logic [3:0]  n_i,
    output logic [15:0] data_o
);

    logic [31:0] dbl;

    // Shift a doubled copy so the wrapped bits land in the upper half.
    always_comb begin
        dbl    = {data_i, data_i} << n_i;
        data_o = dbl[31:16];
    end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-16/16/b key-schedule engine: builds S[0:33] sequentially and holds it.
//
// state | meaning
// IDLE  | reset state, waiting for start
// INIT  | writing S[i] = P16 + i*Q16, one word per cycle
// MIX   | 102 mixing steps over S and L, one per cycle
// DONE  | table complete and frozen, keys_valid high
module rc5_key_expand #(
    parameter int KEY_BYTES = 16
) (
    input  logic               clk,
    input  logic               rst,
    rc5_key_expand_if.slave    kx
);
    import rc5_pkg::*;

    localparam int C     = (KEY_BYTES + 1) / 2;
    localparam int JW    = (C > 1) ? $clog2(C) : 1;
    localparam int MIX_N = mix_steps(C);
    localparam int KW    = $clog2(MIX_N);

    localparam logic [5:0]    LAST_I = 6'(NUM_SUBKEYS - 1);
    localparam logic [JW-1:0] LAST_J = JW'(C - 1);
    localparam logic [KW-1:0] LAST_K = KW'(MIX_N - 1);

    ke_state_t         state_q, state_d;
    logic [WORD_W-1:0] s_q [0:NUM_SUBKEYS-1];
    logic [WORD_W-1:0] l_q [0:C-1];
    logic [WORD_W-1:0] a_q, b_q;
    logic [5:0]        i_q;
    logic [JW-1:0]     j_q;
    logic [KW-1:0]     k_q;

    logic [16*C-1:0]   key_pad;
    logic [WORD_W-1:0] init_word;
    logic [WORD_W-1:0] sum_a, a_new, ab_sum, sum_b, b_new;

    // Odd key lengths read the missing top byte as zero.
    always_comb begin
        key_pad                  = '0;
        key_pad[8*KEY_BYTES-1:0] = kx.key_in;
    end

    // S table initialisation word and the two adder/rotator stages of a mix step.
    always_comb begin
        init_word = (i_q == 6'd0) ? P16 : s_q[i_q - 6'd1] + Q16;
        sum_a     = s_q[i_q] + a_q + b_q;
        ab_sum    = a_new + b_q;
        sum_b     = l_q[j_q] + ab_sum;
    end

    rotl u_rot_a (
        .data_i (sum_a),
        .n_i    (4'd3),
        .data_o (a_new)
    );

    rotl u_rot_b (
        .data_i (sum_b),
        .n_i    (ab_sum[3:0]),
        .data_o (b_new)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= KE_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: start is honoured only in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            KE_IDLE: if (kx.start)        state_d = KE_INIT;
            KE_INIT: if (i_q == LAST_I)   state_d = KE_MIX;
            KE_MIX:  if (k_q == LAST_K)   state_d = KE_DONE;
            KE_DONE: if (kx.start)        state_d = KE_INIT;
            default:                      state_d = KE_IDLE;
        endcase
    end

    // Key latch, S/L table updates and the A/B/i/j/k step registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_SUBKEYS; n++) s_q[n] <= '0;
            for (int n = 0; n < C; n++)           l_q[n] <= '0;
            a_q <= '0;
            b_q <= '0;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            case (state_q)
                KE_IDLE, KE_DONE: begin
                    if (kx.start) begin
                        for (int n = 0; n < C; n++) l_q[n] <= key_pad[16*n +: 16];
                        a_q <= '0;
                        b_q <= '0;
                        i_q <= '0;
                        j_q <= '0;
                        k_q <= '0;
                    end
                end
                KE_INIT: begin
                    s_q[i_q] <= init_word;
                    i_q      <= (i_q == LAST_I) ? 6'd0 : i_q + 6'd1;
                end
                KE_MIX: begin
                    s_q[i_q] <= a_new;
                    l_q[j_q] <= b_new;
                    a_q      <= a_new;
                    b_q      <= b_new;
                    i_q      <= (i_q == LAST_I) ? 6'd0 : i_q + 6'd1;
                    j_q      <= (j_q == LAST_J) ? '0 : j_q + 1'b1;
                    k_q      <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign kx.busy       = (state_q == KE_INIT) || (state_q == KE_MIX);
    assign kx.keys_valid = (state_q == KE_DONE);
    assign kx.subkeys    = s_q;

endmodule
